// File: rtl/prga_fifo_framer_pkg.sv
// Shared definitions for prga_fifo_framer: FSM states, header field layout, checksum seed.
// ST_CKSUM exists only when PRGA_FIFO_FRAMER_CHECKSUM_EN is defined.
package prga_fifo_framer_pkg;

`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CKSUM   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;
`endif

  localparam int LEN_LSB    = 0;
  localparam int CKSUM_SEED = 0;

  // Sequence field starts on the first byte boundary above the length field.
  function automatic int seq_lsb(input int max_payload_log2);
    return ((max_payload_log2 + 8) / 8) * 8;
  endfunction

endpackage

// File: rtl/prga_fifo_framer_buf.sv
// Payload store for prga_fifo_framer: 2**DEPTH_LOG2 registers with write/read pointers.
// The write pointer doubles as the word count; clear empties the store for the next packet.
module prga_fifo_framer_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_adv,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  rd_last
);

  localparam int                DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ONE = 1;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (rd_adv) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = wr_ptr_reg;
  assign rd_last = ({1'b0, rd_ptr_reg} + ONE) == wr_ptr_reg;

endmodule

// File: rtl/prga_fifo_framer.sv
// Packet framer: drains a prga_fifo-style source into {header, payload[, checksum]} packets.
// Define PRGA_FIFO_FRAMER_CHECKSUM_EN to append an XOR trailer word to every packet.
module prga_fifo_framer
  import prga_fifo_framer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int MAX_PAYLOAD_LOG2 = 2,
  parameter int TIMEOUT          = 16,
  parameter int SEQ_WIDTH        = 8,
  parameter int INPUT_LOOKAHEAD  = 0,
  parameter int OUTPUT_LOOKAHEAD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty_i,
  output logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int CW      = MAX_PAYLOAD_LOG2 + 1;
  localparam int IW      = $clog2(TIMEOUT + 1);
  localparam int SEQ_LSB = seq_lsb(MAX_PAYLOAD_LOG2);

  localparam logic [CW-1:0] MAX_CNT     = CW'(2 ** MAX_PAYLOAD_LOG2);
  localparam logic [IW-1:0] TIMEOUT_CNT = IW'(TIMEOUT);

  state_e                state_reg, state_next;
  logic [SEQ_WIDTH-1:0]  seq_reg;
  logic [IW-1:0]         idle_reg;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  out_valid;
  logic                  pop;
  logic                  pkt_done;
  logic                  go_hdr;
  logic                  capture;

  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [CW-1:0]         count;
  logic                  buf_adv;
  logic                  buf_last;

`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_reg;
`endif

  prga_fifo_framer_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MAX_PAYLOAD_LOG2)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pkt_done),
    .wr_en   (capture),
    .wr_data (dout_i),
    .rd_adv  (buf_adv),
    .rd_data (buf_rdata),
    .count   (count),
    .rd_last (buf_last)
  );

  // Non-lookahead sources deliver the word one cycle after the read strobe.
  assign capture = (INPUT_LOOKAHEAD != 0) ? rd_i : inflight_reg;

  // Never leave FILL with a read outstanding, so no word can arrive outside FILL.
  assign go_hdr = (count == MAX_CNT) ||
                  ((count != '0) && (idle_reg == TIMEOUT_CNT) && !inflight_reg);

  always_comb begin
    hdr = '0;
    hdr[LEN_LSB +: CW]        = count;
    hdr[SEQ_LSB +: SEQ_WIDTH] = seq_reg;
  end

  always_comb begin
    state_next = state_reg;
    rd_i       = 1'b0;
    out_valid  = 1'b0;
    cur_word   = '0;
    buf_adv    = 1'b0;
    pkt_done   = 1'b0;
    case (state_reg)
      ST_FILL: begin
        rd_i = rst_n && !go_hdr && !empty_i &&
               ((count + CW'(inflight_reg)) < MAX_CNT);
        if (go_hdr) begin
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        cur_word  = hdr;
        if (rd) begin
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        out_valid = 1'b1;
        cur_word  = buf_rdata;
        if (rd) begin
          buf_adv = 1'b1;
          if (buf_last) begin
`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
            state_next = ST_CKSUM;
`else
            state_next = ST_FILL;
            pkt_done   = 1'b1;
`endif
          end
        end
      end
`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
      ST_CKSUM: begin
        out_valid = 1'b1;
        cur_word  = cksum_reg;
        if (rd) begin
          state_next = ST_FILL;
          pkt_done   = 1'b1;
        end
      end
`endif
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  assign empty = !out_valid;
  assign pop   = rd && out_valid;
  assign dout  = (OUTPUT_LOOKAHEAD != 0) ? cur_word : dout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_FILL;
      seq_reg      <= '0;
      idle_reg     <= '0;
      inflight_reg <= 1'b0;
      dout_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= (INPUT_LOOKAHEAD == 0) && rd_i;
      if (pkt_done) begin
        seq_reg <= seq_reg + SEQ_WIDTH'(1);
      end
      if ((state_reg != ST_FILL) || capture) begin
        idle_reg <= '0;
      end else if ((count != '0) && (idle_reg != TIMEOUT_CNT)) begin
        idle_reg <= idle_reg + IW'(1);
      end
      if (pop) begin
        dout_reg <= cur_word;
      end
    end
  end

`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cksum_reg <= DATA_WIDTH'(CKSUM_SEED);
    end else if (pop && (state_reg == ST_HDR)) begin
      cksum_reg <= DATA_WIDTH'(CKSUM_SEED) ^ hdr;
    end else if (pop && (state_reg == ST_PAYLOAD)) begin
      cksum_reg <= cksum_reg ^ buf_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_prga_fifo_framer.sv
// Four framers (every input/output lookahead combination) fed identical source bursts,
// each drained by a random consumer and checked against a packet-level reference model.
module tb_prga_fifo_framer;

  localparam int DW  = 32;
  localparam int NL  = 4;
  localparam int TO  = 16;
  localparam int MAXP = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NL-1:0]          empty_i;
  logic [NL-1:0]          rd_i;
  logic [NL-1:0][DW-1:0]  dout_i;
  logic [NL-1:0]          empty;
  logic [NL-1:0]          rd;
  logic [NL-1:0][DW-1:0]  dout;

  always #5 clk = ~clk;

  // Lane l: input lookahead = l%2, output lookahead = l/2.
  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    prga_fifo_framer #(
      .DATA_WIDTH       (DW),
      .MAX_PAYLOAD_LOG2 (2),
      .TIMEOUT          (TO),
      .SEQ_WIDTH        (8),
      .INPUT_LOOKAHEAD  (gi % 2),
      .OUTPUT_LOOKAHEAD (gi / 2)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .empty_i (empty_i[gi]),
      .rd_i    (rd_i[gi]),
      .dout_i  (dout_i[gi]),
      .empty   (empty[gi]),
      .rd      (rd[gi]),
      .dout    (dout[gi])
    );
  end

  logic [DW-1:0] src_q [NL][$];
  logic [DW-1:0] exp_q [NL][$];
  int            seq_m;
  int            chk_cnt;
  int            pass_cnt;
  bit            hold;
  bit            pend [NL];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Reference: a burst already queued in the source splits into packets of up to MAXP words.
  task automatic expect_burst(input logic [DW-1:0] w[$]);
    int i;
    int n;
    logic [DW-1:0] hdr;
    logic [DW-1:0] ck;
    i = 0;
    while (i < w.size()) begin
      n   = (w.size() - i < MAXP) ? (w.size() - i) : MAXP;
      hdr = (DW'(seq_m % 256) << 8) | DW'(n);
      ck  = hdr;
      for (int l = 0; l < NL; l++) exp_q[l].push_back(hdr);
      for (int j = 0; j < n; j++) begin
        ck = ck ^ w[i + j];
        for (int l = 0; l < NL; l++) exp_q[l].push_back(w[i + j]);
      end
`ifdef PRGA_FIFO_FRAMER_CHECKSUM_EN
      for (int l = 0; l < NL; l++) exp_q[l].push_back(ck);
`endif
      seq_m = (seq_m + 1) % 256;
      i     = i + n;
    end
  endtask

  task automatic push_src(input logic [DW-1:0] w[$]);
    for (int l = 0; l < NL; l++)
      foreach (w[k]) src_q[l].push_back(w[k]);
  endtask

  task automatic send_burst(input logic [DW-1:0] w[$]);
    expect_burst(w);
    push_src(w);
  endtask

  // prga_fifo-style sources: lookahead lanes show the head word, others deliver after rd_i.
  task automatic src_loop();
    bit pop_req [NL];
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) pop_req[l] = rd_i[l] && !empty_i[l];
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
        if (pop_req[l]) begin
          w = src_q[l].pop_front();
          if (l % 2 == 0) dout_i[l] = w;
        end
        empty_i[l] = (src_q[l].size() == 0);
        if (l % 2 == 1) dout_i[l] = empty_i[l] ? '0 : src_q[l][0];
      end
    end
  endtask

  task automatic cons_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) rd[l] = !hold && ($urandom_range(0, 99) < 60);
    end
  endtask

  task automatic take_word(input int l, input logic [DW-1:0] got);
    if (exp_q[l].size() == 0) begin
      chk_cnt++;
      $display("FAIL lane%0d_unexpected got=%h want=none", l, got);
    end else begin
      check($sformatf("lane%0d_word", l), got, exp_q[l].pop_front());
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (!rst_n) begin
          pend[l] = 1'b0;
        end else begin
          if (pend[l]) begin
            take_word(l, dout[l]);
            pend[l] = 1'b0;
          end
          if (rd[l] && !empty[l]) begin
            if (l / 2 == 1) take_word(l, dout[l]);
            else pend[l] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic bit busy();
    for (int l = 0; l < NL; l++)
      if (exp_q[l].size() != 0 || src_q[l].size() != 0 || pend[l]) return 1'b1;
    return 1'b0;
  endfunction

  // Bounded drain, then an idle window in which any extra output word is flagged.
  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (busy() && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) begin
      chk_cnt++;
      $display("FAIL %s_drain_timeout got=busy want=drained", tag);
    end
    repeat (TO + 12) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] ws[$];
    rst_n    = 1'b0;
    rd       = '0;
    empty_i  = '1;
    dout_i   = '0;
    hold     = 1'b0;
    seq_m    = 0;
    chk_cnt  = 0;
    pass_cnt = 0;
    fork
      src_loop();
      cons_loop();
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d_rst_empty", l), DW'(empty[l]), 32'd1);
      check($sformatf("lane%0d_rst_dout", l), dout[l], 32'd0);
      check($sformatf("lane%0d_rst_rd_i", l), DW'(rd_i[l]), 32'd0);
    end
    rst_n = 1'b1;

    ws = {};
    for (int k = 1; k <= 8; k++) ws.push_back(DW'(k * 32'h11));
    send_burst(ws);
    wait_drain("burst8");

    ws = {32'hA1, 32'hA2, 32'hA3};
    send_burst(ws);
    wait_drain("partial3");

    // Consumer stalled: exactly one packet is taken from the source, nothing else.
    hold = 1'b1;
    ws = {};
    for (int k = 0; k < 8; k++) ws.push_back($urandom);
    send_burst(ws);
    repeat (60) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d_hold_src_left", l), DW'(src_q[l].size()), 32'd4);
      check($sformatf("lane%0d_hold_ready", l), DW'(empty[l]), 32'd0);
    end
    hold = 1'b0;
    wait_drain("hold");

    repeat (6) begin
      ws = {};
      repeat ($urandom_range(1, 9)) ws.push_back($urandom);
      send_burst(ws);
      wait_drain("random");
    end

    // Reset with two words buffered: they vanish and sequence restarts at 0.
    ws = {$urandom, $urandom};
    push_src(ws);
    repeat (8) @(negedge clk);
    for (int l = 0; l < NL; l++)
      check($sformatf("lane%0d_pre_rst_src", l), DW'(src_q[l].size()), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d_midrst_empty", l), DW'(empty[l]), 32'd1);
      check($sformatf("lane%0d_midrst_dout", l), dout[l], 32'd0);
    end
    rst_n = 1'b1;
    seq_m = 0;
    repeat (TO + 8) @(negedge clk);

    ws = {32'h0F, 32'hF0};
    send_burst(ws);
    wait_drain("cksum");

    ws = {};
    for (int k = 0; k < 257 * MAXP; k++) ws.push_back($urandom);
    send_burst(ws);
    wait_drain("seq_wrap");

    for (int l = 0; l < NL; l++)
      check($sformatf("lane%0d_leftover", l), DW'(exp_q[l].size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
